load_store_unit: RTL and testbench

Initiator side of the data memory port. Accepts load/store requests from the KGP-RISC execute stage over a valid/ready handshake and converts them into word-aligned memory beats: address, write data and 4-bit byte-lane write enable. It sequences the memory's synchronous read latency, then returns aligned, sign- or zero-extended load data. Word-crossing accesses are either split into two beats or rejected with an error, depending on configuration.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/load_store_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and latency limits for the load/store unit (MISALIGN_SPLIT_EN adds split states)
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;
    localparam int LAT_CNT_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3
`ifdef MISALIGN_SPLIT_EN
        ,
        ST_ISSUE2 = 3'd4,
        ST_WAIT2  = 3'd5
`endif
    } lsu_state_e;

    // Access width in bytes; 0 for the reserved encoding so it never looks misaligned.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and memory-port bundle of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane mask, store positioning and load extraction
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  k,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  lane_mask,
    output logic [63:0] wdata_pos,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [2:0]  n_bytes;
    logic [31:0] sh;

    // Masks and data span two words so a crossing access splits into low/high beats.
    always_comb begin
        n_bytes    = size_bytes(size);
        lane_mask  = 8'h00;
        case (size)
            SZ_BYTE: lane_mask = 8'h01 << k;
            SZ_HALF: lane_mask = 8'h03 << k;
            SZ_WORD: lane_mask = 8'h0F << k;
            default: lane_mask = 8'h00;
        endcase
        wdata_pos  = {32'h0, wdata} << {k, 3'b000};
        misaligned = ({1'b0, k} + n_bytes) > 3'd4;
        sh         = 32'(rdata >> {k, 3'b000});
        case (size)
            SZ_BYTE: load_data = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: load_data = {{16{sgn & sh[15]}}, sh[15:0]};
            SZ_WORD: load_data = sh;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator FSM; MISALIGN_SPLIT_EN splits word-crossing accesses into two beats
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(RD_LATENCY - 1);

    lsu_state_e           state_q, state_d;
    logic                 we_q, we_d;
    logic [1:0]           size_q, size_d;
    logic [1:0]           k_q, k_d;
    logic                 sgn_q, sgn_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_wren_q, mem_wren_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
`ifdef MISALIGN_SPLIT_EN
    logic                 split_q, split_d;
    logic [3:0]           hi_wren_q, hi_wren_d;
    logic [31:0]          hi_wdata_q, hi_wdata_d;
    logic [31:0]          rdata_lo_q, rdata_lo_d;
`endif

    logic [1:0]  a_k;
    logic [1:0]  a_size;
    logic [63:0] a_rdata;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_pos;
    logic        misaligned;
    logic [31:0] load_data;

    // Align unit looks at the live request while idle, at the registered request afterwards.
    always_comb begin
        a_k     = k_q;
        a_size  = size_q;
        a_rdata = {32'h0, bus.mem_rdata};
        if (state_q == ST_IDLE) begin
            a_k    = bus.req_addr[1:0];
            a_size = bus.req_size;
        end
`ifdef MISALIGN_SPLIT_EN
        if (state_q == ST_WAIT2) begin
            a_rdata = {bus.mem_rdata, rdata_lo_q};
        end
`endif
    end

    lsu_lane_align u_align (
        .k          (a_k),
        .size       (a_size),
        .sgn        (sgn_q),
        .wdata      (bus.req_wdata),
        .rdata      (a_rdata),
        .lane_mask  (lane_mask),
        .wdata_pos  (wdata_pos),
        .misaligned (misaligned),
        .load_data  (load_data)
    );

`ifndef MISALIGN_SPLIT_EN
    logic unused_hi_lanes;
    assign unused_hi_lanes = ^{lane_mask[7:4], wdata_pos[63:32]};
`endif

    // Next-state and register updates for the request/beat/response sequence.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        k_d         = k_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = mem_wren_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef MISALIGN_SPLIT_EN
        split_d     = split_q;
        hi_wren_d   = hi_wren_q;
        hi_wdata_d  = hi_wdata_q;
        rdata_lo_d  = rdata_lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    k_d    = bus.req_addr[1:0];
                    sgn_d  = bus.req_signed;
`ifdef MISALIGN_SPLIT_EN
                    if (bus.req_size == SZ_RSVD) begin
`else
                    if (bus.req_size == SZ_RSVD || misaligned) begin
`endif
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        state_d     = ST_RESP;
                    end else begin
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wren_d  = bus.req_we ? lane_mask[3:0] : 4'h0;
                        mem_wdata_d = bus.req_we ? wdata_pos[31:0] : 32'h0;
`ifdef MISALIGN_SPLIT_EN
                        split_d     = misaligned;
                        hi_wren_d   = bus.req_we ? lane_mask[7:4] : 4'h0;
                        hi_wdata_d  = bus.req_we ? wdata_pos[63:32] : 32'h0;
`endif
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_wren_d = 4'h0;
                if (we_q) begin
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wren_d  = hi_wren_q;
                        mem_wdata_d = hi_wdata_q;
                        state_d     = ST_ISSUE2;
                    end else
`endif
                    begin
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) begin
`ifdef MISALIGN_SPLIT_EN
                    if (split_q) begin
                        rdata_lo_d  = bus.mem_rdata;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wren_d  = hi_wren_q;
                        mem_wdata_d = hi_wdata_q;
                        state_d     = ST_ISSUE2;
                    end else
`endif
                    begin
                        rsp_rdata_d = load_data;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_ISSUE2: begin
                mem_wren_d = 4'h0;
                if (we_q) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (cnt_q == LAT_LAST) begin
                    rsp_rdata_d = load_data;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset also drops any in-flight write enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            k_q         <= 2'b00;
            sgn_q       <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wren_q  <= 4'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            hi_wren_q   <= 4'h0;
            hi_wdata_q  <= 32'h0;
            rdata_lo_q  <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            k_q         <= k_d;
            sgn_q       <= sgn_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef MISALIGN_SPLIT_EN
            split_q     <= split_d;
            hi_wren_q   <= hi_wren_d;
            hi_wdata_q  <= hi_wdata_d;
            rdata_lo_q  <= rdata_lo_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector-table bench for load_store_unit at RD_LATENCY 1 and 3 (honours MISALIGN_SPLIT_EN)
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        d_valid, d_we, d_sgn, d_ready;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;

    load_store_unit_if if1 ();
    load_store_unit_if if3 ();

    load_store_unit #(.RD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    load_store_unit #(.RD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if1.req_valid  = d_valid & ~sel;
    assign if3.req_valid  = d_valid & sel;
    assign if1.req_we     = d_we;
    assign if3.req_we     = d_we;
    assign if1.req_size   = d_size;
    assign if3.req_size   = d_size;
    assign if1.req_signed = d_sgn;
    assign if3.req_signed = d_sgn;
    assign if1.req_addr   = d_addr;
    assign if3.req_addr   = d_addr;
    assign if1.req_wdata  = d_wdata;
    assign if3.req_wdata  = d_wdata;
    assign if1.rsp_ready  = d_ready & ~sel;
    assign if3.rsp_ready  = d_ready & sel;

    // Shared memory model: synchronous read pipelines of depth 1 and 3, byte-lane writes.
    logic [31:0] mem [0:255];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];
    assign if1.mem_rdata = p1;
    assign if3.mem_rdata = p3[2];
    always @(posedge clk) begin
        p1    <= mem[if1.mem_addr[9:2]];
        p3[0] <= mem[if3.mem_addr[9:2]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        for (int i = 0; i < 4; i++) begin
            if (if1.mem_wren[i]) mem[if1.mem_addr[9:2]][8*i +: 8] <= if1.mem_wdata[8*i +: 8];
            if (if3.mem_wren[i]) mem[if3.mem_addr[9:2]][8*i +: 8] <= if3.mem_wdata[8*i +: 8];
        end
    end

    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [31:0] s_rsp_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wren;
    assign s_req_ready = sel ? if3.req_ready : if1.req_ready;
    assign s_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
    assign s_rsp_err   = sel ? if3.rsp_err   : if1.rsp_err;
    assign s_rsp_rdata = sel ? if3.rsp_rdata : if1.rsp_rdata;
    assign s_mem_addr  = sel ? if3.mem_addr  : if1.mem_addr;
    assign s_mem_wdata = sel ? if3.mem_wdata : if1.mem_wdata;
    assign s_mem_wren  = sel ? if3.mem_wren  : if1.mem_wren;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    logic [67:0] beats [$];
    logic [31:0] addrs [$];

    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                           output logic [31:0] rdata, output logic err, output int lat);
        beats.delete();
        addrs.delete();
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'h0, s_req_ready}, 32'd1);
        d_valid = 1'b1; d_we = we; d_size = size; d_sgn = sgn; d_addr = addr; d_wdata = wdata;
        @(negedge clk);
        d_valid = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (s_mem_wren != 4'h0) beats.push_back({s_mem_addr, s_mem_wren, s_mem_wdata});
            if (addrs.size() == 0 || addrs[addrs.size()-1] != s_mem_addr) addrs.push_back(s_mem_addr);
            if (s_rsp_valid) lat = c;
            else chk("busy_req_ready", {31'h0, s_req_ready}, 32'd0);
        end
        if (lat == 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            rdata = s_rsp_rdata;
            err   = s_rsp_err;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_rsp_valid", {31'h0, s_rsp_valid}, 32'd1);
                chk("hold_rdata", s_rsp_rdata, rdata);
                chk("hold_err", {31'h0, s_rsp_err}, {31'h0, err});
                chk("hold_req_ready", {31'h0, s_req_ready}, 32'd0);
            end
            d_ready = 1'b1;
            @(negedge clk);
            d_ready = 1'b0;
            chk("turnaround_req_ready", {31'h0, s_req_ready}, 32'd1);
            chk("turnaround_rsp_valid", {31'h0, s_rsp_valid}, 32'd0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] b1_addr;
        logic [3:0]  b1_wren;
        logic [31:0] b1_wdata;
        logic [31:0] b2_addr;
        logic [3:0]  b2_wren;
        logic [31:0] b2_wdata;
    } vec_t;

    vec_t vt [$];

    function automatic void add(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_beats,
                                input logic [31:0] b1a, input logic [3:0] b1w, input logic [31:0] b1d,
                                input logic [31:0] b2a, input logic [3:0] b2w, input logic [31:0] b2d);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_beats = exp_beats;
        v.b1_addr = b1a; v.b1_wren = b1w; v.b1_wdata = b1d;
        v.b2_addr = b2a; v.b2_wren = b2w; v.b2_wdata = b2d;
        vt.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [67:0] b;

        rst_n = 1'b0; sel = 1'b0;
        d_valid = 1'b0; d_we = 1'b0; d_sgn = 1'b0; d_ready = 1'b0;
        d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;

        // Reset values on both instances.
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_req_ready", {31'h0, s_req_ready}, 32'd1);
            chk("rst_rsp_valid", {31'h0, s_rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", s_rsp_rdata, 32'h0);
            chk("rst_rsp_err",   {31'h0, s_rsp_err}, 32'd0);
            chk("rst_mem_addr",  s_mem_addr, 32'h0);
            chk("rst_mem_wdata", s_mem_wdata, 32'h0);
            chk("rst_mem_wren",  {28'h0, s_mem_wren}, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //   we    size     sgn   addr          wdata         rdata         err  lat beats  beat1                              beat2
        add(1'b1, SZ_WORD, 1'b0, 32'h00000040, 32'h80F01234, 32'h00000000, 1'b0, 2, 1, 32'h040, 4'b1111, 32'h80F01234, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_BYTE, 1'b0, 32'h00000102, 32'h000000AB, 32'h00000000, 1'b0, 2, 1, 32'h100, 4'b0100, 32'h00AB0000, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_HALF, 1'b1, 32'h00000042, 32'h0,        32'hFFFF80F0, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h00000041, 32'h0,        32'h00000012, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_BYTE, 1'b1, 32'h00000043, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_WORD, 1'b1, 32'h00000040, 32'h0,        32'h80F01234, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_HALF, 1'b0, 32'h00000041, 32'h0,        32'h0000F012, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_RSVD, 1'b0, 32'h00000040, 32'h0,        32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_RSVD, 1'b0, 32'h00000040, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_HALF, 1'b0, 32'h00000105, 32'h00001234, 32'h00000000, 1'b0, 2, 1, 32'h104, 4'b0110, 32'h00123400, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_HALF, 1'b0, 32'h00000105, 32'h0,        32'h00001234, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_BYTE, 1'b0, 32'h00000102, 32'h0,        32'h000000AB, 1'b0, 3, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'h5A000000, 32'h00000000, 1'b0, 2, 1, 32'hFFFFFFFC, 4'b1111, 32'h5A000000, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_WORD, 1'b0, 32'h00000000, 32'h00C3B2A1, 32'h00000000, 1'b0, 2, 1, 32'h0, 4'b1111, 32'h00C3B2A1, 32'h0, 4'h0, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        add(1'b1, SZ_WORD, 1'b0, 32'h000000FD, 32'hDDCCBBAA, 32'h00000000, 1'b0, 3, 2, 32'h0FC, 4'b1110, 32'hCCBBAA00, 32'h100, 4'b0001, 32'h000000DD);
        add(1'b0, SZ_WORD, 1'b0, 32'h000000FD, 32'h0,        32'hDDCCBBAA, 1'b0, 5, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_HALF, 1'b1, 32'h000000FF, 32'h0,        32'hFFFFDDCC, 1'b0, 5, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_HALF, 1'b0, 32'h00000103, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 2, 32'h100, 4'b1000, 32'hEF000000, 32'h104, 4'b0001, 32'h000000BE);
        add(1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hC3B2A15A, 1'b0, 5, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
`else
        add(1'b1, SZ_WORD, 1'b0, 32'h000000FD, 32'hDDCCBBAA, 32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'h000000FD, 32'h0,        32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_HALF, 1'b1, 32'h000000FF, 32'h0,        32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b1, SZ_HALF, 1'b0, 32'h00000103, 32'h0000BEEF, 32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
`endif

        foreach (vt[i]) begin
            run_req(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, 0, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_beats", i), 32'(beats.size()), 32'(vt[i].exp_beats));
            if (vt[i].exp_beats >= 1 && beats.size() >= 1) begin
                b = beats[0];
                chk($sformatf("v%0d_b1_addr", i), b[67:36], vt[i].b1_addr);
                chk($sformatf("v%0d_b1_wren", i), {28'h0, b[35:32]}, {28'h0, vt[i].b1_wren});
                chk($sformatf("v%0d_b1_wdata", i), b[31:0], vt[i].b1_wdata);
            end
            if (vt[i].exp_beats >= 2 && beats.size() >= 2) begin
                b = beats[1];
                chk($sformatf("v%0d_b2_addr", i), b[67:36], vt[i].b2_addr);
                chk($sformatf("v%0d_b2_wren", i), {28'h0, b[35:32]}, {28'h0, vt[i].b2_wren});
                chk($sformatf("v%0d_b2_wdata", i), b[31:0], vt[i].b2_wdata);
            end
        end

`ifdef MISALIGN_SPLIT_EN
        // Word load wrapping past the top of the address space.
        run_req(1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'h0, 0, rd, er, lat);
        chk("wrap_rdata", rd, 32'hC3B2A15A);
        chk("wrap_addr_count", 32'(addrs.size()), 32'd2);
        if (addrs.size() >= 2) begin
            chk("wrap_first_addr", addrs[0], 32'hFFFFFFFC);
            chk("wrap_second_addr", addrs[1], 32'h00000000);
        end
`endif

        // Response held back for 5 cycles.
        run_req(1'b0, SZ_BYTE, 1'b0, 32'h00000041, 32'h0, 5, rd, er, lat);
        chk("hold_final_rdata", rd, 32'h00000012);
        chk("hold_latency", 32'(lat), 32'd3);

        // Reset during WAIT of a load.
        @(negedge clk);
        d_valid = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_sgn = 1'b0; d_addr = 32'h40; d_wdata = 32'h0;
        @(negedge clk);
        d_valid = 1'b0;
        chk("rstw_issue_addr", s_mem_addr, 32'h00000040);
        @(negedge clk);
        chk("rstw_busy", {31'h0, s_req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_req_ready", {31'h0, s_req_ready}, 32'd1);
        chk("rstw_rsp_valid", {31'h0, s_rsp_valid}, 32'd0);
        chk("rstw_rsp_rdata", s_rsp_rdata, 32'h0);
        chk("rstw_rsp_err",   {31'h0, s_rsp_err}, 32'd0);
        chk("rstw_mem_addr",  s_mem_addr, 32'h0);
        chk("rstw_mem_wdata", s_mem_wdata, 32'h0);
        chk("rstw_mem_wren",  {28'h0, s_mem_wren}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a store beat drops the write enable immediately.
        @(negedge clk);
        d_valid = 1'b1; d_we = 1'b1; d_size = SZ_BYTE; d_addr = 32'h300; d_wdata = 32'h77;
        @(negedge clk);
        d_valid = 1'b0;
        chk("rsts_wren_live", {28'h0, s_mem_wren}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rsts_wren_dropped", {28'h0, s_mem_wren}, 32'd0);
        chk("rsts_mem_addr", s_mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(1'b0, SZ_WORD, 1'b0, 32'h00000040, 32'h0, 0, rd, er, lat);
        chk("post_rst_rdata", rd, 32'h80F01234);
        chk("post_rst_latency", 32'(lat), 32'd3);

        // RD_LATENCY = 3 instance.
        sel = 1'b1;
        run_req(1'b0, SZ_HALF, 1'b1, 32'h00000042, 32'h0, 0, rd, er, lat);
        chk("l3_half_rdata", rd, 32'hFFFF80F0);
        chk("l3_half_latency", 32'(lat), 32'd5);
        run_req(1'b0, SZ_BYTE, 1'b0, 32'h00000041, 32'h0, 0, rd, er, lat);
        chk("l3_byte_rdata", rd, 32'h00000012);
        chk("l3_byte_latency", 32'(lat), 32'd5);
`ifdef MISALIGN_SPLIT_EN
        run_req(1'b0, SZ_WORD, 1'b0, 32'h000000FD, 32'h0, 0, rd, er, lat);
        chk("l3_split_rdata", rd, 32'hDDCCBBAA);
        chk("l3_split_latency", 32'(lat), 32'd9);
`endif
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
